barrel_shifter_pipe: RTL
========================

// Module: barrel_shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the execute stage: computes the data-processing operand2 and shifter carry-out
//  for LSL/LSR/ASR/ROR/RRX with immediate or register-specified amounts. Shift levels are split across STAGES register
//  stages with a valid/ready handshake on both sides, so it can stall with the ALU. Drop-in successor to the combinational shifter.
// PARAMETERS
//  WIDTH      32  operand width; power of two, >= 8
//  AMT_WIDTH  8   register-specified amount width (Rs[7:0])
//  STAGES     2   pipeline register stages, 1..$clog2(WIDTH)+1; log2 shift levels are distributed evenly across stages, earliest stages get the extras
// PORTS
//  in_Clk         in   1          clock, rising edge
//  in_Reset       in   1          synchronous, active-high reset
//  in_Valid       in   1          upstream request valid
//  out_Ready      out  1          shifter can accept request this cycle
//  in_Val         in   WIDTH      value to shift (Rm or zero-padded imm8)
//  in_Amount      in   AMT_WIDTH  shift amount; imm form uses low $clog2(WIDTH) bits only
//  in_Imm_form    in   1          1 = immediate-encoded amount, 0 = register-specified
//  in_Shift_type  in   2          00 LSL, 01 LSR, 10 ASR, 11 ROR
//  in_C_flag      in   1          CPSR C captured with the request
//  out_Valid      out  1          result valid
//  in_Ready       in   1          downstream accepts result
//  out_Op2        out  WIDTH      shifted operand
//  out_Carry      out  1          shifter carry-out
//  out_Op_count   out  16         accepted-op counter (only with BARREL_SHIFTER_OP_CNT_EN)
// BEHAVIOUR
//  Handshake: transfer in when in_Valid&&out_Ready; out when out_Valid&&in_Ready. out_Op2/out_Carry held stable while out_Valid&&!in_Ready.
//  Each stage advances if its successor is empty or advancing; out_Ready = !stage0_valid || stage0 advances (bubbles collapse, no combinational in_Valid->out_Valid path).
//  Latency exactly STAGES cycles with in_Ready held 1; throughput 1/cycle; ordering preserved; no request dropped or duplicated.
//  Special-case decode (amount==0, amount>=WIDTH) happens in stage 0; stages carry value, remaining amount, type, carry.
//  Imm form, amt==0: LSL -> Op2=val, C=C_in; LSR -> Op2=0, C=val[W-1]; ASR -> Op2={W{val[W-1]}}, C=val[W-1]; ROR -> RRX: Op2={C_in,val[W-1:1]}, C=val[0].
//  Imm form, amt 1..W-1: normal shift; C = last bit shifted out.
//  Reg form, amt==0 (all AMT_WIDTH bits): Op2=val, C=C_in, any type.
//  Reg LSL: amt==W -> 0, C=val[0]; amt>W -> 0, C=0.  Reg LSR: amt==W -> 0, C=val[W-1]; amt>W -> 0, C=0.
//  Reg ASR: amt>=W -> {W{val[W-1]}}, C=val[W-1].  Reg ROR: eff=amt mod W; eff==0 (amt!=0) -> Op2=val, C=val[W-1]; else rotate by eff, C=Op2[W-1].
//  Reset: all stage valids 0, out_Valid=0, out_Op2=0, out_Carry=0, out_Op_count=0; out_Ready=1 the cycle after reset deasserts.
//  Reset mid-operation: all in-flight requests discarded, nothing emitted afterward for them; simultaneous in_Valid ignored.
//  Inputs are sampled only on transfer; changes to inputs while out_Ready=0 have no effect.
// CONFIGURATION
//  BARREL_SHIFTER_OP_CNT_EN defined: out_Op_count increments on each input transfer, saturates at 16'hFFFF, cleared by reset.
//  Not defined: out_Op_count port present, tied to 16'd0, no counter flops.
// TESTING
//  Defaults, in_Ready=1: imm LSL val=32'h0000_00FF amt=4 -> after 2 cycles Op2=32'h0000_0FF0, C=0.
//  Imm ROR amt=0 (RRX), val=32'h0000_0003, C_in=1 -> Op2=32'h8000_0001, C=1; imm LSR amt=0, val=32'h8000_0000 -> Op2=0, C=1.
//  Reg form val=32'h8000_0001: LSL 32 -> 0,C=1; LSL 33 -> 0,C=0; ASR 200 -> 32'hFFFF_FFFF,C=1; ROR 64 -> val,C=1; amt 0 C_in=0 -> val,C=0.
//  Back-to-back 8 random ops, in_Ready toggled 1010..., -> results match golden model in order, Op2/Carry stable during stalls, no loss.
//  Hold in_Ready=0 with pipe full -> out_Ready=0 after STAGES accepts; release -> one result/cycle drains.
//  Assert in_Reset with 2 ops in flight -> next cycle out_Valid=0, out_Op2=0; no stale result appears later; counter 0 (OP_CNT_EN).
//  Sweep STAGES=1,3 and WIDTH=16: latency equals STAGES; LSR reg 16 on WIDTH=16 val=16'h8000 -> 0, C=1.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined LSL/LSR/ASR/ROR/RRX operand2 shifter with valid/ready on both sides.
// Optional accepted-op counter: define BARREL_SHIFTER_OP_CNT_EN.
module barrel_shifter_pipe #(
  parameter int WIDTH     = 32,
  parameter int AMT_WIDTH = 8,
  parameter int STAGES    = 2
) (
  input  logic                 in_Clk,
  input  logic                 in_Reset,
  input  logic                 in_Valid,
  output logic                 out_Ready,
  input  logic [WIDTH-1:0]     in_Val,
  input  logic [AMT_WIDTH-1:0] in_Amount,
  input  logic                 in_Imm_form,
  input  logic [1:0]           in_Shift_type,
  input  logic                 in_C_flag,
  output logic                 out_Valid,
  input  logic                 in_Ready,
  output logic [WIDTH-1:0]     out_Op2,
  output logic                 out_Carry,
  output logic [15:0]          out_Op_count
);

  localparam int LVLS = $clog2(WIDTH);
  localparam int LAST = STAGES - 1;
  localparam logic [AMT_WIDTH:0] WIDTH_A = (AMT_WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_e;

  // First shift level owned by stage s; earlier stages take the remainder levels.
  function automatic int lvl_lo(input int s);
    int base;
    int extra;
    base  = LVLS / STAGES;
    extra = LVLS % STAGES;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  // Applies levels [lo,hi) of the remaining amount; carry is the last bit shifted out.
  function automatic logic [WIDTH:0] apply_levels(input logic [WIDTH-1:0] v_in, input logic c_in,
                                                  input shift_e t, input logic [LVLS-1:0] amt,
                                                  input int lo, input int hi);
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] tmp;
    logic [LVLS-1:0]  a;
    logic             c;
    v = v_in;
    c = c_in;
    for (int k = 0; k < LVLS; k++) begin
      a = amt >> k;
      if (k >= lo && k < hi && a[0]) begin
        case (t)
          SH_LSL: begin tmp = v >> (WIDTH - (1 << k)); c = tmp[0]; v = v << (1 << k); end
          SH_LSR: begin tmp = v >> ((1 << k) - 1); c = tmp[0]; v = v >> (1 << k); end
          SH_ASR: begin tmp = v >> ((1 << k) - 1); c = tmp[0]; v = $signed(v) >>> (1 << k); end
          SH_ROR: begin v = (v >> (1 << k)) | (v << (WIDTH - (1 << k))); c = v[WIDTH-1]; end
          default: begin v = v; c = c; end
        endcase
      end
    end
    return {c, v};
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  val_q  [STAGES];
  logic [LVLS-1:0]   amt_q  [STAGES];
  shift_e            type_q [STAGES];

  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [WIDTH-1:0]  src_val  [STAGES];
  logic [LVLS-1:0]   src_amt  [STAGES];
  shift_e            src_type [STAGES];
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  val_d    [STAGES];
  logic [STAGES-1:0] can_load;

  logic [WIDTH-1:0]  dec_val;
  logic [LVLS-1:0]   dec_amt;
  logic              dec_c;
  logic [LVLS-1:0]   amt_low;
  logic [AMT_WIDTH:0] amt_ext;
  shift_e            in_type;

  assign amt_low = in_Amount[LVLS-1:0];
  assign amt_ext = {1'b0, in_Amount};
  assign in_type = shift_e'(in_Shift_type);

  // Special-case decode: fixed results leave a zero remaining amount.
  always_comb begin
    dec_val = in_Val;
    dec_amt = amt_low;
    dec_c   = in_C_flag;
    if (in_Imm_form) begin
      if (amt_low == '0) begin
        case (in_type)
          SH_LSL:  begin dec_val = in_Val; dec_c = in_C_flag; end
          SH_LSR:  begin dec_val = '0; dec_c = in_Val[WIDTH-1]; end
          SH_ASR:  begin dec_val = {WIDTH{in_Val[WIDTH-1]}}; dec_c = in_Val[WIDTH-1]; end
          SH_ROR:  begin dec_val = {in_C_flag, in_Val[WIDTH-1:1]}; dec_c = in_Val[0]; end
          default: begin dec_val = in_Val; dec_c = in_C_flag; end
        endcase
      end else begin
        dec_amt = amt_low;
      end
    end else if (in_Amount == '0) begin
      dec_amt = '0;
    end else begin
      case (in_type)
        SH_LSL: begin
          if (amt_ext == WIDTH_A) begin
            dec_val = '0; dec_c = in_Val[0]; dec_amt = '0;
          end else if (amt_ext > WIDTH_A) begin
            dec_val = '0; dec_c = 1'b0; dec_amt = '0;
          end else begin
            dec_amt = amt_low;
          end
        end
        SH_LSR: begin
          if (amt_ext == WIDTH_A) begin
            dec_val = '0; dec_c = in_Val[WIDTH-1]; dec_amt = '0;
          end else if (amt_ext > WIDTH_A) begin
            dec_val = '0; dec_c = 1'b0; dec_amt = '0;
          end else begin
            dec_amt = amt_low;
          end
        end
        SH_ASR: begin
          if (amt_ext >= WIDTH_A) begin
            dec_val = {WIDTH{in_Val[WIDTH-1]}}; dec_c = in_Val[WIDTH-1]; dec_amt = '0;
          end else begin
            dec_amt = amt_low;
          end
        end
        SH_ROR: begin
          if (amt_low == '0) begin
            dec_c = in_Val[WIDTH-1]; dec_amt = '0;
          end else begin
            dec_amt = amt_low;
          end
        end
        default: dec_amt = '0;
      endcase
    end
  end

  // Per-stage datapath: each stage applies its share of shift levels to its source.
  always_comb begin
    src_valid   = '0;
    src_carry   = '0;
    carry_d     = '0;
    src_valid[0] = in_Valid;
    src_val[0]   = dec_val;
    src_amt[0]   = dec_amt;
    src_type[0]  = in_type;
    src_carry[0] = dec_c;
    for (int s = 1; s < STAGES; s++) begin
      src_valid[s] = valid_q[s-1];
      src_val[s]   = val_q[s-1];
      src_amt[s]   = amt_q[s-1];
      src_type[s]  = type_q[s-1];
      src_carry[s] = carry_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      {carry_d[s], val_d[s]} = apply_levels(src_val[s], src_carry[s], src_type[s], src_amt[s],
                                            lvl_lo(s), lvl_lo(s + 1));
    end
  end

  // Backpressure chain: a stage may load when empty or when its content moves on.
  always_comb begin
    logic ready_chain;
    ready_chain = in_Ready;
    can_load    = '0;
    for (int s = LAST; s >= 0; s--) begin
      ready_chain = !valid_q[s] || ready_chain;
      can_load[s] = ready_chain;
    end
  end

  // Stage registers; data only captured for valid entries so the output holds during stalls.
  always_ff @(posedge in_Clk) begin
    if (in_Reset) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        val_q[s]  <= '0;
        amt_q[s]  <= '0;
        type_q[s] <= SH_LSL;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (can_load[s]) begin
          valid_q[s] <= src_valid[s];
          if (src_valid[s]) begin
            val_q[s]   <= val_d[s];
            amt_q[s]   <= src_amt[s];
            type_q[s]  <= src_type[s];
            carry_q[s] <= carry_d[s];
          end
        end
      end
    end
  end

  assign out_Ready = can_load[0];
  assign out_Valid = valid_q[LAST];
  assign out_Op2   = val_q[LAST];
  assign out_Carry = carry_q[LAST];

`ifdef BARREL_SHIFTER_OP_CNT_EN
  logic [15:0] op_cnt_q;

  // Saturating count of accepted requests.
  always_ff @(posedge in_Clk) begin
    if (in_Reset) begin
      op_cnt_q <= 16'd0;
    end else if (in_Valid && out_Ready && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign out_Op_count = op_cnt_q;
`else
  assign out_Op_count = 16'd0;
`endif

endmodule
